alien_bomb_move: RTL and testbench

- Downward counterpart of the player projectile: moves one alien bomb from a shooter alien toward the player ship.
- Each shot is preceded by a pseudo-random cooldown. The block latches the launch position from the alien matrix and advances the bomb once per frame in 1/64-pixel fixed point, accelerating downward.
- The bomb retires on collision (ship, shield or player shot) or on reaching the bottom limit.
- Sits beside the projectile mover and feeds the bomb drawing object and collision logic.

---
 rtl/alien_bomb_move_if.sv | 25 ++
 rtl/alien_bomb_move.sv | 149 ++++++++++++++
 tb/tb_alien_bomb_move.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/alien_bomb_move_if.sv
// Signal bundle between the alien bomb mover and its neighbours.
// The frame timing, collision and shooter inputs come from the game logic.
// The launch acknowledge and bomb position go back to the matrix and drawing logic.
interface alien_bomb_move_if;
  logic        startOfFrame;
  logic        enable_sof;
  logic        collision;
  logic        alien_valid;
  logic [10:0] alien_x;
  logic [10:0] alien_y;
  logic        fire_ack;
  logic        active;
  logic [10:0] bomb_x;
  logic [10:0] bomb_y;

  modport master (
    output startOfFrame, enable_sof, collision, alien_valid, alien_x, alien_y,
    input  fire_ack, active, bomb_x, bomb_y
  );

  modport slave (
    input  startOfFrame, enable_sof, collision, alien_valid, alien_x, alien_y,
    output fire_ack, active, bomb_x, bomb_y
  );
endinterface

// File: rtl/alien_bomb_move.sv
// Alien bomb mover.
// After a pseudo-random cooldown, the bomb launches from the shooter alien.
// It then falls in 1/64-pixel fixed point with capped downward acceleration.
// It retires on a collision or when it reaches the bottom limit.
module alien_bomb_move #(
  parameter int unsigned FIXED_POINT_MULTIPLIER = 64,
  parameter int unsigned INIT_SPEED             = 128,
  parameter int unsigned ACC                    = 8,
  parameter int unsigned MAX_SPEED              = 384,
  parameter int unsigned Y_OFFSET               = 16,
  parameter int unsigned Y_FRAME_BOTTOM         = 461,
  parameter int unsigned COOLDOWN_MIN           = 30,
  parameter int unsigned COOLDOWN_RAND_MASK     = 5'h1F,
  parameter logic [15:0] LFSR_SEED              = 16'hACE1
) (
  input logic              clk,
  input logic              reset,
  alien_bomb_move_if.slave bus
);

  localparam int LOG2_FPM = $clog2(FIXED_POINT_MULTIPLIER);

  localparam logic signed [31:0] FPM_S    = 32'(FIXED_POINT_MULTIPLIER);
  localparam logic signed [31:0] INIT_S   = 32'(INIT_SPEED);
  localparam logic signed [31:0] ACC_S    = 32'(ACC);
  localparam logic signed [31:0] MAX_S    = 32'(MAX_SPEED);
  localparam logic signed [31:0] YOFF_S   = 32'(Y_OFFSET);
  localparam logic signed [31:0] BOTTOM_S = 32'(Y_FRAME_BOTTOM * FIXED_POINT_MULTIPLIER);
  localparam logic [15:0]        CD_MIN   = 16'(COOLDOWN_MIN);
  localparam logic [4:0]         CD_MASK  = 5'(COOLDOWN_RAND_MASK);

  typedef enum logic [2:0] {
    COOLDOWN_ST   = 3'd0,
    ARM_ST        = 3'd1,
    MOVE_ST       = 3'd2,
    SOF_ST        = 3'd3,
    POS_CHANGE_ST = 3'd4,
    LIMITS_ST     = 3'd5
  } state_t;

  state_t             state;
  logic signed [31:0] ypos;
  logic signed [31:0] speed;
  logic [10:0]        xpix;      // X is launched on a whole pixel and never moves
  logic               hit;
  logic [15:0]        lfsr;
  logic [15:0]        cooldown;
  logic               sof;
  logic               ypos_unused;

  // Fibonacci LFSR, taps 16,14,13,11, shifting towards the MSB.
  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return {cur[14:0], cur[15] ^ cur[13] ^ cur[12] ^ cur[10]};
  endfunction

  // Cooldown reload: minimum plus a masked random slice of the LFSR.
  function automatic logic [15:0] cooldown_reload(input logic [15:0] cur);
    return CD_MIN + {11'd0, cur[4:0] & CD_MASK};
  endfunction

  // Add the acceleration and clip the result at the speed ceiling.
  function automatic logic signed [31:0] speed_next(input logic signed [31:0] cur);
    logic signed [31:0] sum;
    sum = cur + ACC_S;
    return (sum > MAX_S) ? MAX_S : sum;
  endfunction

  assign sof         = bus.startOfFrame & bus.enable_sof;
  assign bus.bomb_x  = xpix;
  assign bus.bomb_y  = ypos[LOG2_FPM +: 11];
  assign ypos_unused = ^{ypos[31:LOG2_FPM+11], ypos[LOG2_FPM-1:0]};

  // Bomb state machine, LFSR and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= COOLDOWN_ST;
      ypos         <= 32'sd0;
      speed        <= 32'sd0;
      xpix         <= 11'd0;
      hit          <= 1'b0;
      lfsr         <= LFSR_SEED;
      cooldown     <= CD_MIN;
      bus.active   <= 1'b0;
      bus.fire_ack <= 1'b0;
    end else begin
      lfsr         <= lfsr_next(lfsr);
      bus.fire_ack <= 1'b0;
      case (state)
        COOLDOWN_ST: begin
          bus.active <= 1'b0;
          if (sof) begin
            if (cooldown == 16'd0) begin
              state <= ARM_ST;
            end else begin
              cooldown <= cooldown - 16'd1;
            end
          end
        end
        ARM_ST: begin
          if (sof && bus.alien_valid) begin
            xpix         <= bus.alien_x;
            ypos         <= ($signed({21'd0, bus.alien_y}) + YOFF_S) * FPM_S;
            speed        <= INIT_S;
            bus.active   <= 1'b1;
            bus.fire_ack <= 1'b1;
            state        <= MOVE_ST;
          end
        end
        MOVE_ST: begin
          if (bus.collision) begin
            hit <= 1'b1;
          end
          if (sof) begin
            state <= SOF_ST;
          end
        end
        SOF_ST: begin
          if (hit) begin
            bus.active <= 1'b0;
            hit        <= 1'b0;
            cooldown   <= cooldown_reload(lfsr);
            state      <= COOLDOWN_ST;
          end else begin
            state <= POS_CHANGE_ST;
          end
        end
        POS_CHANGE_ST: begin
          ypos  <= ypos + speed;
          speed <= speed_next(speed);
          state <= LIMITS_ST;
        end
        LIMITS_ST: begin
          if (ypos >= BOTTOM_S) begin
            ypos       <= BOTTOM_S;
            bus.active <= 1'b0;
            cooldown   <= cooldown_reload(lfsr);
            state      <= COOLDOWN_ST;
          end else begin
            state <= MOVE_ST;
          end
        end
        default: begin
          state <= COOLDOWN_ST;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alien_bomb_move.sv
// Randomized scoreboard bench for alien_bomb_move.
// A frame-level reference model predicts launches and per-frame bomb positions.
// A monitor compares the DUT against the queued predictions.
module tb_alien_bomb_move;

  localparam int CD_MIN  = 3;
  localparam int BOTTOM  = 461 * 64;

  logic clk;
  logic reset;
  alien_bomb_move_if bus();

  alien_bomb_move #(
    .COOLDOWN_MIN       (CD_MIN),
    .COOLDOWN_RAND_MASK (0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct { int x; int y; } fire_t;
  typedef struct { bit act; int x; int y; } frame_t;

  fire_t  fire_q[$];
  frame_t frame_q[$];

  int n_vec = 0;
  int n_err = 0;

  // Reference model: 0 = cooling down, 1 = armed, 2 = in flight.
  int m_phase, m_cd, m_x, m_y, m_speed;
  bit m_active, m_hit;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_cd = CD_MIN; m_x = 0; m_y = 0; m_speed = 0;
    m_active = 1'b0; m_hit = 1'b0;
  endtask

  // One accepted frame event applied to the model; queues the expected outcome.
  task automatic model_sof(input bit av, input int ax, input int ay);
    fire_t  f;
    frame_t e;
    case (m_phase)
      0: begin
        if (m_cd == 0) m_phase = 1;
        else m_cd--;
      end
      1: begin
        if (av) begin
          m_x = ax; m_y = (ay + 16) * 64; m_speed = 128;
          m_active = 1'b1; m_phase = 2;
          f.x = ax; f.y = (ay + 16) % 2048;
          fire_q.push_back(f);
        end
      end
      default: begin
        if (m_hit) begin
          m_hit = 1'b0; m_active = 1'b0; m_cd = CD_MIN; m_phase = 0;
        end else begin
          m_y = m_y + m_speed;
          m_speed = (m_speed + 8 > 384) ? 384 : m_speed + 8;
          if (m_y >= BOTTOM) begin
            m_y = BOTTOM; m_active = 1'b0; m_cd = CD_MIN; m_phase = 0;
          end
        end
      end
    endcase
    e.act = m_active; e.x = m_x % 2048; e.y = (m_y / 64) % 2048;
    frame_q.push_back(e);
  endtask

  // One 8-cycle frame: a startOfFrame pulse, then an optional mid-frame collision pulse.
  task automatic frame(input bit en, input bit av, input int ax, input int ay, input bit col);
    @(posedge clk); #1;
    bus.startOfFrame = 1'b1;
    bus.enable_sof   = en;
    bus.alien_valid  = av;
    bus.alien_x      = 11'(ax);
    bus.alien_y      = 11'(ay);
    if (en) model_sof(av, ax, ay);
    @(posedge clk); #1;
    bus.startOfFrame = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    if (col) begin
      bus.collision = 1'b1;
      if (m_phase == 2) m_hit = 1'b1;
    end
    @(posedge clk); #1;
    bus.collision = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  // Monitor: checks launches on fire_ack and positions once each frame's update has settled.
  initial begin
    int    cnt;
    fire_t f;
    frame_t e;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        cnt = 0;
      end else begin
        if (bus.fire_ack) begin
          if (fire_q.size() == 0) begin
            chk("unexpected_fire_ack", 1, 0);
          end else begin
            f = fire_q.pop_front();
            chk("fire_x", int'(bus.bomb_x), f.x);
            chk("fire_y", int'(bus.bomb_y), f.y);
            chk("fire_active", int'(bus.active), 1);
          end
        end
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            if (frame_q.size() == 0) begin
              chk("frame_queue_underrun", 1, 0);
            end else begin
              e = frame_q.pop_front();
              chk("frame_active", int'(bus.active), int'(e.act));
              chk("frame_x", int'(bus.bomb_x), e.x);
              chk("frame_y", int'(bus.bomb_y), e.y);
            end
          end
        end
        if (bus.startOfFrame && bus.enable_sof) cnt = 4;
      end
    end
  end

  // Stimulus: directed scenarios first, then randomized frames.
  initial begin
    bit en, av, col;
    model_reset();
    reset = 1'b1;
    bus.startOfFrame = 1'b0; bus.enable_sof = 1'b1; bus.collision = 1'b0;
    bus.alien_valid = 1'b0; bus.alien_x = 11'd0; bus.alien_y = 11'd0;
    #12;
    chk("reset_active", int'(bus.active), 0);
    chk("reset_fire_ack", int'(bus.fire_ack), 0);
    chk("reset_bomb_x", int'(bus.bomb_x), 0);
    chk("reset_bomb_y", int'(bus.bomb_y), 0);
    @(posedge clk); #1;
    reset = 1'b0;

    // Cooldown, launch at (100,50), then an uninterrupted fall to the bottom.
    for (int i = 0; i < 5; i++) frame(1'b1, 1'b1, 100, 50, 1'b0);
    for (int i = 0; i < 90; i++) frame(1'b1, 1'b0, 100, 50, 1'b0);
    // Armed with no valid shooter for many frames; raising alien_valid fires.
    frame(1'b1, 1'b1, 200, 80, 1'b0);
    // Fly until y reaches 120, then a collision retires the bomb.
    for (int i = 0; i < 100 && m_active && (m_y / 64) < 120; i++) frame(1'b1, 1'b0, 0, 0, 1'b0);
    frame(1'b1, 1'b0, 0, 0, 1'b1);
    frame(1'b1, 1'b0, 0, 0, 1'b0);
    // Relaunch, then pause the game for 10 frame pulses mid-flight.
    for (int i = 0; i < 8; i++) frame(1'b1, 1'b1, 300, 40, 1'b0);
    for (int i = 0; i < 10; i++) frame(1'b0, 1'b1, 300, 40, 1'b0);
    for (int i = 0; i < 3; i++) frame(1'b1, 1'b0, 300, 40, 1'b0);
    chk("model_in_flight_before_reset", int'(m_active), 1);

    // Asynchronous reset mid-flight, checked before any clock edge.
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    chk("async_reset_active", int'(bus.active), 0);
    chk("async_reset_bomb_x", int'(bus.bomb_x), 0);
    chk("async_reset_bomb_y", int'(bus.bomb_y), 0);
    model_reset();
    @(posedge clk); #1;
    reset = 1'b0;

    // Randomized frames.
    for (int i = 0; i < 350; i++) begin
      en  = ($urandom % 8) != 0;
      av  = ($urandom % 4) != 0;
      col = ($urandom % 10) == 0;
      frame(en, av, int'($urandom_range(0, 600)), int'($urandom_range(0, 300)), col);
    end

    repeat (10) @(posedge clk);
    chk("fire_queue_drained", fire_q.size(), 0);
    chk("frame_queue_drained", frame_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
